imem_instr_encoder: RTL and testbench
=====================================

Name: imem_instr_encoder

Overview:
- Encoder and writer counterpart to the opcode type decoder: builds RV32I instruction words from an instruction class plus fields.
- Streams the encoded words into instruction memory at consecutive word addresses.
- Used by the bench/boot loader to program imem ahead of the single-cycle core; sits on the imem write port.
- Sequential: 4-state FSM, word counter, valid/ready input handshake, one-cycle write pipeline.

Parameters:
ADDR_W, 12, byte-address width of imem write port
MAX_WORDS, 256, words writable per session before overflow error

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin session (pulse), honoured only in IDLE
base_addr  in  ADDR_W  first byte address, latched on start; bits[1:0] forced to 0
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept bundle
in_class  in  4  0 R,1 I,2 LOAD,3 STORE,4 BRANCH,5 JAL,6 JALR,7 LUI,8 AUIPC; 9-15 illegal
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R only)
in_imm  in  32  immediate, full value (LUI/AUIPC: bits[31:12] used)
in_last  in  1  final bundle of session
mem_we  out  1  imem write strobe
mem_addr  out  ADDR_W  imem byte address
mem_wdata  out  32  encoded instruction
busy  out  1  FSM not IDLE
done  out  1  one-cycle pulse at session end
err_class  out  1  sticky: illegal class seen; cleared on start
err_ovf  out  1  sticky: MAX_WORDS exceeded; cleared on start
word_cnt  out  ADDR_W-1  words written this session

Behaviour:
- Reset (async, any state): FSM->IDLE; in_ready, mem_we, busy, done, err_* = 0; mem_addr, mem_wdata, word_cnt = 0.
- States: IDLE, ACCEPT, WRITE, FINISH.
- IDLE: in_ready=0. On start: latch base_addr, clear word_cnt and err_*, go to ACCEPT.
- ACCEPT: in_ready=1. On in_valid: register encoded word, address and in_last, go to WRITE. Illegal class: set err_class, no write; go to FINISH if in_last, else stay in ACCEPT.
- WRITE: in_ready=0; mem_we=1 for exactly one cycle with mem_addr=base+4*word_cnt. Increment word_cnt. Next state is FINISH if the latched last flag is set or word_cnt+1==MAX_WORDS, else ACCEPT.
- Throughput: 1 word per 2 cycles. Write lands the cycle after acceptance.
- Overflow: a bundle accepted in ACCEPT when word_cnt==MAX_WORDS is unreachable by construction. If the MAX_WORDS limit ends a session without in_last, set err_ovf.
- FINISH: done=1 for one cycle, then IDLE.
- start while busy: ignored.
- mem_addr wraps modulo 2^ADDR_W; no error is raised for address wrap.
- Encoding: standard RV32I field placement.
  - Opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Immediates are truncated to their format: I/S 12 bits, B imm[12:1], J imm[20:1], U imm[31:12].
  - Fields unused by a format are ignored. funct7 is used only for R; I-type shifts supply imm[11:5] in in_imm.

Optional Feature:
- Macro: IMEM_ENC_IMM_CHECK_EN.
- Defined:
  - Extra sticky output err_imm (cleared on start).
  - Set when in_imm does not sign-fit its format (I/S/JALR: [-2048,2047]; B: [-4096,4094] and even; J: ±1 MiB and even) or when U imm[11:0]!=0.
  - The offending bundle is consumed but not written, handled like an illegal class.
- Undefined: no err_imm port; silent truncation.

Decomposition:
- Package imem_enc_pkg: class codes (CLS_R..CLS_AUIPC), the 9 opcode constants, and format-width constants.
- Natural sub-module: imem_enc_pack, a combinational class+fields -> 32-bit word plus illegal flag; the FSM wrapper registers its output.

Test Plan:
- start base=0x100, in_class=I rd=1 rs1=0 f3=0 imm=5 last=1 -> mem_we one cycle, addr 0x100, wdata 0x00500093; done pulse; word_cnt=1.
- Back-to-back R add x3,x1,x2 / STORE sw x2,8(x1) / BRANCH beq x1,x2,+8 -> writes 0x002081B3@base, 0x0020A423@base+4, 0x00208463@base+8; in_ready low on every WRITE cycle.
- JAL rd=1 imm=16, then LUI rd=5 imm=0x12345000 last=1 -> 0x010000EF, 0x123452B7.
- in_class=12 mid-stream -> err_class=1, no mem_we for that bundle, next legal word at the unskipped address; err_class cleared by the next start.
- MAX_WORDS=4, feed 6 bundles without in_last -> exactly 4 writes, err_ovf=1, done, in_ready=0 afterwards. Assert rst during WRITE -> mem_we drops immediately and all outputs return to 0.
- With IMEM_ENC_IMM_CHECK_EN: I imm=4096 -> err_imm=1, no write. Without the macro: writes a word with imm field 0x000.

Source files
------------

// File: rtl/imem_enc_pkg.sv
// Shared constants for the RV32I instruction encoder.
// Holds class codes, opcodes, immediate widths, FSM states and a sign-fit helper.
package imem_enc_pkg;

    localparam logic [3:0] CLS_R      = 4'd0;
    localparam logic [3:0] CLS_I      = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_JALR   = 4'd6;
    localparam logic [3:0] CLS_LUI    = 4'd7;
    localparam logic [3:0] CLS_AUIPC  = 4'd8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int IMM_I_W = 12;
    localparam int IMM_S_W = 12;
    localparam int IMM_B_W = 13;
    localparam int IMM_J_W = 21;
    localparam int IMM_U_LSB = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_FINISH
    } enc_state_e;

    // True when v is representable as a w-bit two's complement value.
    function automatic logic sfits(input logic [31:0] v, input int w);
        logic [31:0] s;
        s = $unsigned($signed(v) >>> (w - 1));
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imem_instr_encoder_if.sv
// Field-bundle valid/ready channel into the instruction encoder.
// master: bundle producer (drives fields, in_valid, in_last); slave: encoder (drives in_ready).
interface imem_instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_class;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_last;

    modport master (
        output in_valid, in_class, in_rd, in_rs1, in_rs2,
        output in_funct3, in_funct7, in_imm, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_class, in_rd, in_rs1, in_rs2,
        input  in_funct3, in_funct7, in_imm, in_last,
        output in_ready
    );

endinterface

// File: rtl/imem_enc_pack.sv
// Combinational RV32I packer: class + fields -> 32-bit word and illegal flag.
// Ports: cls_i, rd_i, rs1_i, rs2_i, f3_i, f7_i, imm_i in; word_o, illegal_o
// (and imm_bad_o when IMEM_ENC_IMM_CHECK_EN is defined) out.
module imem_enc_pack
    import imem_enc_pkg::*;
(
    input  logic [3:0]  cls_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  f3_i,
    input  logic [6:0]  f7_i,
    input  logic [31:0] imm_i,
`ifdef IMEM_ENC_IMM_CHECK_EN
    output logic        imm_bad_o,
`endif
    output logic [31:0] word_o,
    output logic        illegal_o
);

    logic bad;

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        bad       = 1'b0;
        case (cls_i)
            CLS_R: begin
                word_o = {f7_i, rs2_i, rs1_i, f3_i, rd_i, OP_R};
            end
            CLS_I: begin
                word_o = {imm_i[11:0], rs1_i, f3_i, rd_i, OP_I};
                bad    = !sfits(imm_i, IMM_I_W);
            end
            CLS_LOAD: begin
                word_o = {imm_i[11:0], rs1_i, f3_i, rd_i, OP_LOAD};
                bad    = !sfits(imm_i, IMM_I_W);
            end
            CLS_STORE: begin
                word_o = {imm_i[11:5], rs2_i, rs1_i, f3_i,
                          imm_i[4:0], OP_STORE};
                bad    = !sfits(imm_i, IMM_S_W);
            end
            CLS_BRANCH: begin
                word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i,
                          imm_i[4:1], imm_i[11], OP_BRANCH};
                bad    = !sfits(imm_i, IMM_B_W) || imm_i[0];
            end
            CLS_JAL: begin
                word_o = {imm_i[20], imm_i[10:1], imm_i[11],
                          imm_i[19:12], rd_i, OP_JAL};
                bad    = !sfits(imm_i, IMM_J_W) || imm_i[0];
            end
            CLS_JALR: begin
                word_o = {imm_i[11:0], rs1_i, f3_i, rd_i, OP_JALR};
                bad    = !sfits(imm_i, IMM_I_W);
            end
            CLS_LUI: begin
                word_o = {imm_i[31:12], rd_i, OP_LUI};
                bad    = |imm_i[IMM_U_LSB-1:0];
            end
            CLS_AUIPC: begin
                word_o = {imm_i[31:12], rd_i, OP_AUIPC};
                bad    = |imm_i[IMM_U_LSB-1:0];
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

`ifdef IMEM_ENC_IMM_CHECK_EN
    assign imm_bad_o = bad;
`else
    // Without the range check the format simply truncates the immediate.
    logic unused_bad;
    assign unused_bad = bad;
`endif

endmodule

// File: rtl/imem_instr_encoder.sv
// Session FSM that encodes RV32I bundles and streams them into imem.
// Ports: clk, rst, start, base_addr; in_if (slave bundle channel);
// mem_we/mem_addr/mem_wdata write port; busy, done, err_class, err_ovf,
// word_cnt status (plus err_imm when IMEM_ENC_IMM_CHECK_EN is defined).
module imem_instr_encoder
    import imem_enc_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    imem_instr_encoder_if.slave in_if,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_class,
    output logic              err_ovf,
`ifdef IMEM_ENC_IMM_CHECK_EN
    output logic              err_imm,
`endif
    output logic [ADDR_W-2:0] word_cnt
);

    localparam logic [31:0] MAXW = 32'(MAX_WORDS);

    enc_state_e        state_q;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              err_class_q;
    logic              err_ovf_q;
    logic [ADDR_W-2:0] word_cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic              last_q;

    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              enc_bad;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-2:0] cnt_d;
    logic [31:0]       cnt_ext;
    logic              hit_max;

`ifdef IMEM_ENC_IMM_CHECK_EN
    logic err_imm_q;
    logic imm_bad;
`endif

    imem_enc_pack u_pack (
        .cls_i     (in_if.in_class),
        .rd_i      (in_if.in_rd),
        .rs1_i     (in_if.in_rs1),
        .rs2_i     (in_if.in_rs2),
        .f3_i      (in_if.in_funct3),
        .f7_i      (in_if.in_funct7),
        .imm_i     (in_if.in_imm),
`ifdef IMEM_ENC_IMM_CHECK_EN
        .imm_bad_o (imm_bad),
`endif
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

`ifdef IMEM_ENC_IMM_CHECK_EN
    assign enc_bad = enc_illegal | imm_bad;
`else
    assign enc_bad = enc_illegal;
`endif

    // Address wraps modulo 2^ADDR_W; the count's top bit drops out here.
    assign addr_d  = base_q + {word_cnt_q[ADDR_W-3:0], 2'b00};
    assign cnt_d   = word_cnt_q + 1'b1;
    assign cnt_ext = {{(33-ADDR_W){1'b0}}, word_cnt_q};
    assign hit_max = (cnt_ext + 32'd1) == MAXW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_class_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            word_cnt_q  <= '0;
            base_q      <= '0;
            last_q      <= 1'b0;
`ifdef IMEM_ENC_IMM_CHECK_EN
            err_imm_q   <= 1'b0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q      <= {base_addr[ADDR_W-1:2], 2'b00};
                        word_cnt_q  <= '0;
                        err_class_q <= 1'b0;
                        err_ovf_q   <= 1'b0;
`ifdef IMEM_ENC_IMM_CHECK_EN
                        err_imm_q   <= 1'b0;
`endif
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (in_if.in_valid) begin
                        if (enc_bad) begin
                            // Rejected bundles are consumed without a write.
                            if (enc_illegal) err_class_q <= 1'b1;
`ifdef IMEM_ENC_IMM_CHECK_EN
                            else err_imm_q <= 1'b1;
`endif
                            if (in_if.in_last) begin
                                in_ready_q <= 1'b0;
                                done_q     <= 1'b1;
                                state_q    <= S_FINISH;
                            end
                        end else begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= addr_d;
                            mem_wdata_q <= enc_word;
                            last_q      <= in_if.in_last;
                            in_ready_q  <= 1'b0;
                            state_q     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    word_cnt_q <= cnt_d;
                    if (last_q || hit_max) begin
                        if (!last_q) err_ovf_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= S_ACCEPT;
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_class      = err_class_q;
    assign err_ovf        = err_ovf_q;
    assign word_cnt       = word_cnt_q;
`ifdef IMEM_ENC_IMM_CHECK_EN
    assign err_imm        = err_imm_q;
`endif

endmodule

// File: tb/tb_imem_instr_encoder.sv
// Directed bench for imem_instr_encoder (MAX_WORDS overridden to 4).
// Each scenario task drives bundles and checks logged writes inline.
module tb_imem_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy, done, err_class, err_ovf;
    logic [10:0] word_cnt;
`ifdef IMEM_ENC_IMM_CHECK_EN
    logic        err_imm;
`endif

    int errors = 0;
    int checks = 0;

    logic [11:0] wa[$];
    logic [31:0] wd[$];
    int          viol = 0;
    int          done_cnt = 0;

    imem_instr_encoder_if in_if ();

    imem_instr_encoder #(.ADDR_W(12), .MAX_WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_if     (in_if),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err_class (err_class),
        .err_ovf   (err_ovf),
`ifdef IMEM_ENC_IMM_CHECK_EN
        .err_imm   (err_imm),
`endif
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            if (in_if.in_ready) viol++;
        end
        if (done) done_cnt++;
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        viol = 0;
    endtask

    task automatic begin_session(input logic [11:0] b);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] c, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last);
        int n;
        @(negedge clk);
        in_if.in_class  = c;
        in_if.in_rd     = rd;
        in_if.in_rs1    = rs1;
        in_if.in_rs2    = rs2;
        in_if.in_funct3 = f3;
        in_if.in_funct7 = f7;
        in_if.in_imm    = imm;
        in_if.in_last   = last;
        in_if.in_valid  = 1'b1;
        n = 0;
        while (!in_if.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_if.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_if.in_ready);
        end else begin
            @(negedge clk);
        end
        in_if.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done_cnt=%0d required %0d", done_cnt, target);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 6;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: %b req 0", mem_we); end
        if (mem_addr !== 12'h000) begin errors++; $display("FAIL rst_addr: %h req 000", mem_addr); end
        if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: %h req 0", mem_wdata); end
        if (in_if.in_ready !== 1'b0) begin errors++; $display("FAIL rst_rdy: %b req 0", in_if.in_ready); end
        if ({busy, done, err_class, err_ovf} !== 4'b0) begin
            errors++; $display("FAIL rst_flags: %b req 0000", {busy, done, err_class, err_ovf});
        end
        if (word_cnt !== 11'd0) begin errors++; $display("FAIL rst_cnt: %0d req 0", word_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int d0 = done_cnt;
        clear_log();
        begin_session(12'h100);
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        wait_done(d0 + 1);
        @(negedge clk);
        #1;
        checks += 5;
        if (wa.size() !== 1) begin errors++; $display("FAIL single_n: %0d req 1", wa.size()); end
        else begin
            if (wa[0] !== 12'h100) begin errors++; $display("FAIL single_addr: %h req 100", wa[0]); end
            if (wd[0] !== 32'h00500093) begin errors++; $display("FAIL single_data: %h req 00500093", wd[0]); end
        end
        if (word_cnt !== 11'd1) begin errors++; $display("FAIL single_cnt: %0d req 1", word_cnt); end
        if (done_cnt !== d0 + 1 || busy !== 1'b0) begin
            errors++; $display("FAIL single_done: pulses=%0d busy=%b req 1,0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        clear_log();
        begin_session(12'h200);
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        begin_session(12'h7F0);
        send(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
        send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b1);
        wait_done(d0 + 1);
        checks += 2;
        if (wa.size() !== 3) begin errors++; $display("FAIL b2b_n: %0d req 3", wa.size()); end
        else begin
            checks += 6;
            if (wa[0] !== 12'h200) begin errors++; $display("FAIL b2b_a0: %h req 200", wa[0]); end
            if (wd[0] !== 32'h002081B3) begin errors++; $display("FAIL b2b_d0: %h req 002081B3", wd[0]); end
            if (wa[1] !== 12'h204) begin errors++; $display("FAIL b2b_a1: %h req 204", wa[1]); end
            if (wd[1] !== 32'h0020A423) begin errors++; $display("FAIL b2b_d1: %h req 0020A423", wd[1]); end
            if (wa[2] !== 12'h208) begin errors++; $display("FAIL b2b_a2: %h req 208", wa[2]); end
            if (wd[2] !== 32'h00208463) begin errors++; $display("FAIL b2b_d2: %h req 00208463", wd[2]); end
        end
        if (viol !== 0) begin errors++; $display("FAIL b2b_rdy_in_write: %0d cycles req 0", viol); end
    endtask

    task automatic test_jal_lui();
        int d0 = done_cnt;
        clear_log();
        begin_session(12'h300);
        send(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b0);
        send(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1);
        wait_done(d0 + 1);
        checks++;
        if (wa.size() !== 2) begin errors++; $display("FAIL jl_n: %0d req 2", wa.size()); end
        else begin
            checks += 3;
            if (wd[0] !== 32'h010000EF) begin errors++; $display("FAIL jal_data: %h req 010000EF", wd[0]); end
            if (wd[1] !== 32'h123452B7) begin errors++; $display("FAIL lui_data: %h req 123452B7", wd[1]); end
            if (wa[1] !== 12'h304) begin errors++; $display("FAIL lui_addr: %h req 304", wa[1]); end
        end
    endtask

    task automatic test_illegal();
        int d0 = done_cnt;
        clear_log();
        begin_session(12'h400);
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        send(4'd12, 5'd9, 5'd9, 5'd9, 3'd0, 7'd0, 32'd0, 1'b0);
        send(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1);
        wait_done(d0 + 1);
        checks += 3;
        if (err_class !== 1'b1) begin errors++; $display("FAIL ill_err: %b req 1", err_class); end
        if (word_cnt !== 11'd2) begin errors++; $display("FAIL ill_cnt: %0d req 2", word_cnt); end
        if (wa.size() !== 2) begin errors++; $display("FAIL ill_n: %0d req 2", wa.size()); end
        else begin
            checks++;
            if (wa[1] !== 12'h404 || wd[1] !== 32'h123452B7) begin
                errors++; $display("FAIL ill_next: %h@%h req 123452B7@404", wd[1], wa[1]);
            end
        end
        begin_session(12'h500);
        #1;
        checks++;
        if (err_class !== 1'b0) begin errors++; $display("FAIL ill_clear: %b req 0", err_class); end
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        wait_done(d0 + 2);
    endtask

    task automatic test_overflow();
        int d0 = done_cnt;
        logic rdy_seen = 1'b0;
        clear_log();
        begin_session(12'hFF8);
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        send(4'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0);
        send(4'd1, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0);
        send(4'd1, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 1'b0);
        // Bundles 5 and 6 are offered but must never be taken.
        @(negedge clk);
        in_if.in_valid = 1'b1;
        in_if.in_last  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (in_if.in_ready) rdy_seen = 1'b1;
        end
        in_if.in_valid = 1'b0;
        #1;
        checks += 6;
        if (wa.size() !== 4) begin errors++; $display("FAIL ovf_n: %0d req 4", wa.size()); end
        else begin
            checks += 2;
            if (wa[2] !== 12'h000) begin errors++; $display("FAIL ovf_wrap: %h req 000", wa[2]); end
            if (wa[3] !== 12'h004 || wd[3] !== 32'h00400213) begin
                errors++; $display("FAIL ovf_last: %h@%h req 00400213@004", wd[3], wa[3]);
            end
        end
        if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_err: %b req 1", err_ovf); end
        if (done_cnt !== d0 + 1) begin errors++; $display("FAIL ovf_done: %0d req 1", done_cnt - d0); end
        if (rdy_seen !== 1'b0) begin errors++; $display("FAIL ovf_rdy: %b req 0", rdy_seen); end
        if (word_cnt !== 11'd4) begin errors++; $display("FAIL ovf_cnt: %0d req 4", word_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy: %b req 0", busy); end
    endtask

    task automatic test_reset_in_write();
        int n = 0;
        begin_session(12'h600);
        @(negedge clk);
        in_if.in_class = 4'd1;
        in_if.in_last  = 1'b0;
        in_if.in_valid = 1'b1;
        while (!mem_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!mem_we) begin errors++; $display("FAIL rw_no_write: mem_we=%b req 1", mem_we); end
        rst = 1'b1;
        #1;
        checks += 4;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL rw_we: %b req 0", mem_we); end
        if (mem_addr !== 12'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL rw_bus: %h %h req 0 0", mem_addr, mem_wdata);
        end
        if ({busy, in_if.in_ready, done} !== 3'b0) begin
            errors++; $display("FAIL rw_ctl: %b req 000", {busy, in_if.in_ready, done});
        end
        if (word_cnt !== 11'd0 || err_ovf !== 1'b0) begin
            errors++; $display("FAIL rw_cnt: %0d %b req 0 0", word_cnt, err_ovf);
        end
        in_if.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_imm();
        int d0 = done_cnt;
        clear_log();
        begin_session(12'h700);
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b1);
        wait_done(d0 + 1);
        checks += 2;
`ifdef IMEM_ENC_IMM_CHECK_EN
        if (err_imm !== 1'b1) begin errors++; $display("FAIL imm_err: %b req 1", err_imm); end
        if (wa.size() !== 0) begin errors++; $display("FAIL imm_nowrite: %0d req 0", wa.size()); end
`else
        if (wa.size() !== 1) begin errors++; $display("FAIL imm_n: %0d req 1", wa.size()); end
        else if (wd[0] !== 32'h00000093) begin
            errors++; $display("FAIL imm_trunc: %h req 00000093", wd[0]);
        end
        if (err_class !== 1'b0) begin errors++; $display("FAIL imm_cls: %b req 0", err_class); end
`endif
    endtask

    initial begin
        in_if.in_valid  = 1'b0;
        in_if.in_class  = '0;
        in_if.in_rd     = '0;
        in_if.in_rs1    = '0;
        in_if.in_rs2    = '0;
        in_if.in_funct3 = '0;
        in_if.in_funct7 = '0;
        in_if.in_imm    = '0;
        in_if.in_last   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_jal_lui();
        test_illegal();
        test_overflow();
        test_reset_in_write();
        test_imm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
